// File: rtl/bcd_pkg.sv
// Shared constants, state type and helpers for the digit-serial BCD add/sub block.
package bcd_pkg;

  localparam int         NIBBLE_W = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Control states of the serial add/sub sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nine's complement of one BCD digit; with an initial carry of 1 this
  // turns the digit adder into a ten's-complement subtractor.
  function automatic logic [NIBBLE_W-1:0] nines_comp(input logic [NIBBLE_W-1:0] nibble);
    return BCD_MAX - nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit decimal adder: digit = (x + y + cin) mod 10, cout = sum >= 10.
// Inputs are expected to be 0..9, so the raw sum never exceeds 19.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] digit,
  output logic                cout
);

  logic [NIBBLE_W:0] w_t;

  // Binary add then decimal correction by subtracting ten when needed.
  always_comb begin
    w_t = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};
    if (w_t >= 5'd10) begin
      digit = NIBBLE_W'(w_t - 5'd10);
      cout  = 1'b1;
    end else begin
      digit = w_t[NIBBLE_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// the producer holds valid and data stable until that edge, and the block
// holds out_valid, sum, cout and err stable until it sees out_ready.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic [NIBBLE_W*DIGITS-1:0] a,
  input  logic [NIBBLE_W*DIGITS-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIBBLE_W*DIGITS-1:0] sum,
  output logic                       cout,
  output logic                       err,
  output logic [1:0]                 dbg_state
);

  localparam int W     = NIBBLE_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_mode;
  logic                r_carry;
  logic                r_err_lat;
  logic [W-1:0]        r_sum;
  logic                r_out_valid;
  logic                r_cout;
  logic                r_err;

  logic                w_bad;
  logic [NIBBLE_W-1:0] w_x;
  logic [NIBBLE_W-1:0] w_y;
  logic [NIBBLE_W-1:0] w_digit;
  logic                w_cout;

  // Flag any non-decimal nibble in either incoming operand.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX || b[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX)
        w_bad = 1'b1;
    end
  end

  // Operands are shifted right each digit, so the current digit is always the low nibble.
  always_comb begin
    w_x = r_a[NIBBLE_W-1:0];
    w_y = r_mode ? nines_comp(r_b[NIBBLE_W-1:0]) : r_b[NIBBLE_W-1:0];
  end

  bcd_digit_adder u_digit_adder (
    .x     (w_x),
    .y     (w_y),
    .cin   (r_carry),
    .digit (w_digit),
    .cout  (w_cout)
  );

  // Sequencer: capture, one digit per cycle, then present and hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 1'b0;
      r_carry     <= 1'b0;
      r_err_lat   <= 1'b0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Bad operands are replaced by zero so nothing undefined reaches the adder.
            r_a       <= w_bad ? '0 : a;
            r_b       <= w_bad ? '0 : b;
            r_mode    <= mode;
            r_carry   <= mode;
            r_err_lat <= w_bad;
            r_cnt     <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum[r_cnt*NIBBLE_W +: NIBBLE_W] <= w_digit;
          r_carry <= w_cout;
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIGITS - 1))
            r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the final flags; out_valid rises after it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_cout      <= r_err_lat ? 1'b0 : r_carry;
            r_err       <= r_err_lat;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_err ? '0 : r_sum;
  assign cout      = r_cout;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomised and directed bench for bcd_serial_addsub against an integer-arithmetic model.
module tb_bcd_serial_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results, packed as {err, cout, sum}.
  logic [W+1:0] exp_q[$];

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint bcd_to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m);
    longint p = 1;
    longint x, y, r;
    logic   c;
    bit     bad = 0;
    for (int i = 0; i < D; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
      p = p * 10;
    end
    if (bad) return {1'b1, 1'b0, {W{1'b0}}};
    x = bcd_to_int(av);
    y = bcd_to_int(bv);
    if (!m) begin
      r = x + y;
      c = (r >= p);
      r = r % p;
    end else begin
      c = (x >= y);
      r = (x - y + p) % p;
    end
    return {1'b0, c, int_to_bcd(r)};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issue one operation, wait for its result, optionally stall the consumer,
  // score the result and confirm the block returns to idle after the drain.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m, input int stall);
    int           lat;
    logic [W+1:0] e;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    a         = av;
    b         = bv;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(model(av, bv, m));
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(D + 1));
    e = exp_q.pop_front();
    check("result", 64'({err, cout, sum}), 64'(e));
    for (int s = 0; s < stall; s++) begin
      // A competing request while the result is held must be ignored.
      a        = rand_bcd();
      b        = rand_bcd();
      in_valid = 1'b1;
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_hold", 64'({err, cout, sum}), 64'(e));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drained_valid", 64'(out_valid), 64'(0));
    check("drained_in_ready", 64'(in_ready), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra, rb;
    bit           seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst_n = 1'b1;

    // Directed cases from the operating envelope.
    run_op(16'h1234, 16'h5678, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 0);
    run_op(16'h9999, 16'h9999, 1'b0, 0);
    run_op(16'h5000, 16'h1234, 1'b1, 0);
    run_op(16'h1234, 16'h5000, 1'b1, 0);
    run_op(16'h0777, 16'h0777, 1'b1, 0);
    run_op(16'h12A4, 16'h0001, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 0);

    // Backpressure, then a fresh operation accepted after the drain.
    run_op(16'h0042, 16'h0058, 1'b0, 6);
    run_op(16'h1111, 16'h2222, 1'b0, 0);

    // Reset two cycles into an operation: result must be discarded.
    @(negedge clk);
    a        = 16'h1234;
    b        = 16'h4321;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    rst_n = 1'b1;
    seen  = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_result", 64'(seen), 64'(0));
    run_op(16'h0005, 16'h0005, 1'b0, 0);

    // Random operations, occasionally with a corrupt nibble and consumer stalls.
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
